regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined CPU, the successor to the single-write/dual-read file. It provides NUM_READ combinational read ports, NUM_WRITE synchronous write ports with same-cycle write-to-read bypass, and a per-register pending-write scoreboard for the hazard unit. After reset, a clear sequencer sweeps the storage to zero one entry per cycle, so the array maps to RAM-style storage without a wide asynchronous clear.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 77 +++++++
 rtl/regfile_mp.sv | 164 ++++++++++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
// Holds the clear-sequencer state encoding and the default geometry that
// the decode and hazard stages also use to size their address/data buses.
package regfile_pkg;

  // Default geometry shared with decode and hazard logic
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DEPTH      = 2 ** RF_ADDR_WIDTH;
  localparam int RF_NUM_READ   = 2;
  localparam int RF_NUM_WRITE  = 2;

  // Clear sequencer: sweep storage to zero, then serve accesses
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending-write bit per register for the hazard unit.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (clears all bits)
//   en_i               block is out of the clear sweep; busy forced low otherwise
//   wr_vld_i           qualified write strobes (already masked for r0 / sweep)
//   wr_addr_i          write addresses, port j in slice j
//   res_vld_i          qualified reserve strobe
//   res_addr_i         register to mark pending
//   rd_addr_i          read addresses, port k in slice k
//   rd_busy_o          port k register pending and not written this cycle
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = RF_NUM_READ,
  parameter int NUM_WRITE  = RF_NUM_WRITE,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic [NUM_WRITE-1:0]            wr_vld_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                            res_vld_i,
  input  logic [ADDR_WIDTH-1:0]           res_addr_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [NUM_READ-1:0]             rd_busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] sb_q;
  logic [DEPTH-1:0] sb_d;

  // Pending-bit update: writes clear, then a reserve sets (new producer wins)
  always_comb begin
    sb_d = sb_q;
    for (int j = 0; j < NUM_WRITE; j++) begin
      sb_d[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] =
        wr_vld_i[j] ? 1'b0 : sb_d[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]];
    end
    sb_d[res_addr_i] = res_vld_i ? 1'b1 : sb_d[res_addr_i];
  end

  // Pending-bit register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= {DEPTH{1'b0}};
    end else begin
      sb_q <= sb_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_busy
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  hit_s;

    assign addr_s = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

    // Busy lookup: a write landing this cycle resolves the hazard already
    always_comb begin
      hit_s = 1'b0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        hit_s = hit_s | (wr_vld_i[j] &
                (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == addr_s));
      end
      if (!en_i) begin
        rd_busy_o[k] = 1'b0;
      end else if (ZERO_REG && (addr_s == {ADDR_WIDTH{1'b0}})) begin
        rd_busy_o[k] = 1'b0;
      end else begin
        rd_busy_o[k] = sb_q[addr_s] & ~hit_s;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and pending-write
// scoreboard. After reset a sequencer zeroes one entry per cycle so the array
// needs no wide asynchronous clear.
// Ports:
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset
//   ready_o      high once the clear sweep has completed
//   rd_addr_i    read addresses, port k in slice k
//   rd_data_o    combinational read data, port k in slice k
//   rd_busy_o    port k register has a pending write not completing this cycle
//   wr_en_i      per-port write enable
//   wr_addr_i    write addresses, port j in slice j
//   wr_data_i    write data, port j in slice j
//   res_en_i     reserve strobe (producer issued)
//   res_addr_i   register to reserve
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = RF_NUM_READ,
  parameter int NUM_WRITE  = RF_NUM_WRITE,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  output logic                            ready_o,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data_o,
  output logic [NUM_READ-1:0]             rd_busy_o,
  input  logic [NUM_WRITE-1:0]            wr_en_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data_i,
  input  logic                            res_en_i,
  input  logic [ADDR_WIDTH-1:0]           res_addr_i
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  rf_state_e             state_q;
  rf_state_e             state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  is_ready_s;
  logic [NUM_WRITE-1:0]  wr_vld_s;
  logic                  res_vld_s;

  assign is_ready_s = (state_q == ST_READY);
  assign ready_o    = is_ready_s;

  // Clear sequencer next state: walk every entry once, then hold READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Clear sequencer state and sweep counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write qualification: ignored during sweep, r0 dropped when hard-wired
  always_comb begin
    wr_vld_s = {NUM_WRITE{1'b0}};
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (ZERO_REG && (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == {ADDR_WIDTH{1'b0}})) begin
        wr_vld_s[j] = 1'b0;
      end else begin
        wr_vld_s[j] = is_ready_s & wr_en_i[j];
      end
    end
  end

  // Reserve qualification: same masking as writes
  always_comb begin
    if (ZERO_REG && (res_addr_i == {ADDR_WIDTH{1'b0}})) begin
      res_vld_s = 1'b0;
    end else begin
      res_vld_s = is_ready_s & res_en_i;
    end
  end

  // Storage: no reset so it maps to RAM; higher write port is applied last
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_vld_s[j]) begin
          mem_q[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] byp_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign addr_s = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_s;

    // Read path: zero register, then same-cycle bypass (highest port), then storage
    always_comb begin
      byp_s = mem_q[addr_s];
      for (int j = 0; j < NUM_WRITE; j++) begin
        byp_s = (wr_vld_s[j] && (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == addr_s))
                ? wr_data_i[j*DATA_WIDTH +: DATA_WIDTH] : byp_s;
      end
      if (!is_ready_s) begin
        data_s = {DATA_WIDTH{1'b0}};
      end else if (ZERO_REG && (addr_s == {ADDR_WIDTH{1'b0}})) begin
        data_s = {DATA_WIDTH{1'b0}};
      end else begin
        data_s = byp_s;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (is_ready_s),
    .wr_vld_i   (wr_vld_s),
    .wr_addr_i  (wr_addr_i),
    .res_vld_i  (res_vld_s),
    .res_addr_i (res_addr_i),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (rd_busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with default parameters.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_regfile_mp;

  logic        clk_i;
  logic        rst_ni;
  logic        ready_o;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic [1:0]  wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [63:0] wr_data_i;
  logic        res_en_i;
  logic [4:0]  res_addr_i;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_mp dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ready_o    (ready_o),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .res_en_i   (res_en_i),
    .res_addr_i (res_addr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr_i = {a1, a0};
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    wr_en_i   = en;
    wr_addr_i = {a1, a0};
    wr_data_i = {d1, d0};
  endtask

  initial begin
    rst_ni     = 1'b0;
    rd_addr_i  = 10'd0;
    wr_en_i    = 2'b00;
    wr_addr_i  = 10'd0;
    wr_data_i  = 64'd0;
    res_en_i   = 1'b0;
    res_addr_i = 5'd0;

    // Reset state
    repeat (2) @(negedge clk_i);
    set_rd(5'd5, 5'd9);
    #1;
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_rd0", rd_data_o[31:0], 32'd0);
    check("rst_busy", {30'd0, rd_busy_o}, 32'd0);

    // Sweep: Ready low for 32 edges; writes and reserves ignored
    rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      if (i == 3) begin
        res_en_i   = 1'b1;
        res_addr_i = 5'd4;
        set_wr(2'b10, 5'd0, 32'd0, 5'd31, 32'hCAFE_F00D);
      end else begin
        res_en_i = 1'b0;
        set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      end
      #1;
      check("sweep_ready", {31'd0, ready_o}, 32'd0);
      check("sweep_rd0", rd_data_o[31:0], 32'd0);
      check("sweep_busy", {30'd0, rd_busy_o}, 32'd0);
      tick();
    end
    res_en_i = 1'b0;
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_rd(5'd4, 5'd31);
    #1;
    check("ready_after_32", {31'd0, ready_o}, 32'd1);
    check("r4_not_reserved", {30'd0, rd_busy_o}, 32'd0);
    check("r31_cleared", rd_data_o[63:32], 32'd0);

    // Same-cycle bypass on port 0 write, port 1 read
    set_wr(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
    set_rd(5'd6, 5'd5);
    #1;
    check("bypass_r5", rd_data_o[63:32], 32'hDEAD_BEEF);
    check("r6_zero", rd_data_o[31:0], 32'd0);
    tick();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("stored_r5", rd_data_o[63:32], 32'hDEAD_BEEF);

    // Both ports write r7: port 1 wins in bypass and storage
    set_wr(2'b11, 5'd7, 32'h1111_1111, 5'd7, 32'h2222_2222);
    set_rd(5'd7, 5'd5);
    #1;
    check("bypass_r7_prio", rd_data_o[31:0], 32'h2222_2222);
    tick();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("stored_r7_prio", rd_data_o[31:0], 32'h2222_2222);
    check("r5_kept", rd_data_o[63:32], 32'hDEAD_BEEF);

    // Port 0 alone writes r7 (no port-1 conflict)
    set_wr(2'b01, 5'd7, 32'h3333_3333, 5'd0, 32'd0);
    #1;
    check("bypass_r7_p0", rd_data_o[31:0], 32'h3333_3333);
    tick();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

    // r0 hard-wired: no write, no bypass, no reserve
    set_wr(2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    res_en_i   = 1'b1;
    res_addr_i = 5'd0;
    set_rd(5'd0, 5'd7);
    #1;
    check("r0_no_bypass", rd_data_o[31:0], 32'd0);
    check("r0_busy", {31'd0, rd_busy_o[0]}, 32'd0);
    check("r7_stored_p0", rd_data_o[63:32], 32'h3333_3333);
    tick();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    res_en_i = 1'b0;
    #1;
    check("r0_after", rd_data_o[31:0], 32'd0);
    check("r0_busy_after", {31'd0, rd_busy_o[0]}, 32'd0);

    // Reserve r3: busy from the next cycle
    res_en_i   = 1'b1;
    res_addr_i = 5'd3;
    set_rd(5'd3, 5'd4);
    #1;
    check("res_same_cycle", {30'd0, rd_busy_o}, 32'd0);
    tick();
    res_en_i = 1'b0;
    #1;
    check("res_next_cycle", {30'd0, rd_busy_o}, 32'd1);
    tick();
    #1;
    check("res_held", {30'd0, rd_busy_o}, 32'd1);

    // Write r3 on port 1: busy drops in the write cycle and stays low
    set_wr(2'b10, 5'd0, 32'd0, 5'd3, 32'hA5A5_A5A5);
    #1;
    check("wr_clears_busy", {30'd0, rd_busy_o}, 32'd0);
    check("wr_r3_bypass", rd_data_o[31:0], 32'hA5A5_A5A5);
    tick();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    check("busy_after_wr", {30'd0, rd_busy_o}, 32'd0);

    // Reserve and write r3 together: reserve wins
    set_wr(2'b01, 5'd3, 32'h0000_0003, 5'd0, 32'd0);
    res_en_i   = 1'b1;
    res_addr_i = 5'd3;
    tick();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    res_en_i = 1'b0;
    #1;
    check("res_beats_wr", {30'd0, rd_busy_o}, 32'd1);
    check("r3_data", rd_data_o[31:0], 32'h0000_0003);

    // Write r9, run on, then reset mid-operation
    set_wr(2'b01, 5'd9, 32'h1234_5678, 5'd0, 32'd0);
    tick();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    repeat (4) tick();
    set_rd(5'd9, 5'd3);
    #1;
    check("r9_stored", rd_data_o[31:0], 32'h1234_5678);
    check("r3_busy_pre_rst", {31'd0, rd_busy_o[1]}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_ready_drop", {31'd0, ready_o}, 32'd0);
    check("rst_rd_drop", rd_data_o[31:0], 32'd0);
    check("rst_busy_drop", {30'd0, rd_busy_o}, 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (31) tick();
    #1;
    check("resweep_ready_31", {31'd0, ready_o}, 32'd0);
    tick();
    #1;
    check("resweep_ready_32", {31'd0, ready_o}, 32'd1);
    check("r9_cleared", rd_data_o[31:0], 32'd0);
    check("r3_busy_cleared", {30'd0, rd_busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
